// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, registered operands, registered response with
// valid/ready handshake. Illegal op codes bypass the ALU and return an error.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   reqX_valid/ready/op/a/b          requester ports 0 and 1 (ready is combinational)
//   alu_ctrl, alu_a, alu_b           registered operands to the ALU
//   alu_result                       combinational ALU result
//   rsp_valid/ready/id/result/err    response channel
//   busy                             high whenever the block is not idle
module alu_arbiter #(
  parameter int unsigned        DATA_W = 32,
  parameter int unsigned        RES_W  = 64,
  parameter int unsigned        OP_W   = 4,
  parameter logic [OP_W-1:0]    OP_MAX = OP_W'(4'hB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [OP_W-1:0]     ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic                grant_vld;
  logic                grant_id;
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ctrl_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  // Grant selection, next-state and register updates
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    // Contention goes to the port that did not win last time
    grant_vld = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    sel_op    = grant_id ? req1_op : req0_op;
    sel_a     = grant_id ? req1_a  : req0_a;
    sel_b     = grant_id ? req1_b  : req0_b;

    unique case (state_q)
      IDLE: begin
        req0_ready = grant_vld & ~grant_id;
        req1_ready = grant_vld &  grant_id;
        if (grant_vld) begin
          ctrl_d       = sel_op;
          a_d          = sel_a;
          b_d          = sel_b;
          owner_d      = grant_id;
          last_grant_d = grant_id;
          if (sel_op > OP_MAX) begin
            // Illegal op: answer immediately without using the ALU
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant_id;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_err_d    = 1'b0;
        rsp_valid_d  = 1'b1;
        rsp_id_d     = owner_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign alu_ctrl   = ctrl_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a random phase,
// all checked every cycle against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b;
  logic [63:0] alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [63:0] rsp_result;

  always #5 clk = ~clk;

  // ALU stub: concatenation of the operands
  assign alu_result = {alu_a, alu_b};

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: at most one transaction in flight
  logic        m_outst = 1'b0;
  logic        m_last  = 1'b1;
  int          m_since = 0;
  logic        e_id, e_ill;
  logic [3:0]  e_op;
  logic [31:0] e_a, e_b;
  logic [63:0] e_res;
  logic        acc0, acc1;
  logic [65:0] resp_log[$];   // {id, err, result} as seen on the DUT

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: check outputs against the model, then advance the model
  task automatic cycle();
    logic g_vld, g, exp_v, fire;
    acc0 = 1'b0;
    acc1 = 1'b0;
    #1;
    g_vld = !m_outst && (req0_valid || req1_valid);
    g     = (req0_valid && req1_valid) ? !m_last : req1_valid;
    exp_v = m_outst && (m_since >= (e_ill ? 0 : 1));
    chk("req0_ready", 64'(req0_ready), 64'(g_vld && !g));
    chk("req1_ready", 64'(req1_ready), 64'(g_vld && g));
    chk("busy", 64'(busy), 64'(m_outst));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
    if (exp_v) begin
      chk("rsp_id", 64'(rsp_id), 64'(e_id));
      chk("rsp_err", 64'(rsp_err), 64'(e_ill));
      chk("rsp_result", rsp_result, e_res);
    end
    if (m_outst && !e_ill && m_since == 0) begin
      chk("alu_ctrl", 64'(alu_ctrl), 64'(e_op));
      chk("alu_a", 64'(alu_a), 64'(e_a));
      chk("alu_b", 64'(alu_b), 64'(e_b));
    end
    fire = exp_v && rsp_ready && rst_n;
    if (fire) resp_log.push_back({rsp_id, rsp_err, rsp_result});
    @(posedge clk);
    if (!rst_n) begin
      m_outst = 1'b0;
      m_last  = 1'b1;
    end else begin
      if (fire) m_outst = 1'b0;
      else if (m_outst) m_since++;
      if (g_vld) begin
        m_outst = 1'b1;
        m_since = 0;
        m_last  = g;
        e_id    = g;
        e_op    = g ? req1_op : req0_op;
        e_a     = g ? req1_a  : req0_a;
        e_b     = g ? req1_b  : req0_b;
        e_ill   = e_op > 4'hB;
        e_res   = e_ill ? 64'h0 : {e_a, e_b};
        if (g) acc1 = 1'b1; else acc0 = 1'b1;
      end
    end
    #1;
  endtask

  // Cycle until all presented requests are served and the block is idle
  task automatic run(input int maxc);
    int n = 0;
    while ((req0_valid || req1_valid || m_outst) && n < maxc) begin
      cycle();
      n++;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    if (n >= maxc) chk("timeout", 64'(n), 64'(maxc - 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic chk_log(input string tag, input logic id, input logic err, input logic [63:0] res);
    logic [65:0] ent;
    if (resp_log.size() == 0) chk({tag, "_missing"}, 64'(0), 64'(1));
    else begin
      ent = resp_log.pop_front();
      chk({tag, "_id"}, 64'(ent[65]), 64'(id));
      chk({tag, "_err"}, 64'(ent[64]), 64'(err));
      chk({tag, "_res"}, ent[63:0], res);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    chk("rst_rsp_result", rsp_result, 64'h0);
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
    chk("rst_alu_ab", {alu_a, alu_b}, 64'h0);

    // Single request on port 0
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'h000000B5; req0_b = 32'h0000000D;
    run(20);
    chk_log("single", 1'b0, 1'b0, 64'h000000B5_0000000D);

    // Simultaneous requests from reset, twice
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req0_valid = 1'b1; req0_op = 4'h1; req0_a = 32'd1; req0_b = 32'd2;
      req1_valid = 1'b1; req1_op = 4'h2; req1_a = 32'd3; req1_b = 32'd4;
      run(30);
      chk_log("simul_first", 1'b0, 1'b0, 64'h00000001_00000002);
      chk_log("simul_second", 1'b1, 1'b0, 64'h00000003_00000004);
    end

    // Backpressure: response held for 5 cycles while port 1 waits
    req0_valid = 1'b1; req0_op = 4'h3; req0_a = 32'hCAFE0000; req0_b = 32'h0000BEEF;
    rsp_ready = 1'b0;
    for (int i = 0; i < 20 && !acc0; i++) cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'h4; req1_a = 32'h11111111; req1_b = 32'h22222222;
    for (int i = 0; i < 6; i++) cycle();
    rsp_ready = 1'b1;
    run(20);
    chk_log("bp_first", 1'b0, 1'b0, 64'hCAFE0000_0000BEEF);
    chk_log("bp_second", 1'b1, 1'b0, 64'h11111111_22222222);

    // Illegal op on port 1
    req1_valid = 1'b1; req1_op = 4'hC; req1_a = 32'hFFFFFFFF; req1_b = 32'hFFFFFFFF;
    run(20);
    chk_log("illegal", 1'b1, 1'b1, 64'h0);

    // Reset while in EXEC drops the request
    req1_valid = 1'b1; req1_op = 4'h5; req1_a = 32'hDEAD0001; req1_b = 32'h0BAD0002;
    for (int i = 0; i < 20 && !acc1; i++) cycle();
    req1_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("midrst_nolog", 64'(resp_log.size()), 64'(0));
    req1_valid = 1'b1; req1_op = 4'h6; req1_a = 32'h12345678; req1_b = 32'h9ABCDEF0;
    run(20);
    chk_log("midrst_next", 1'b1, 1'b0, 64'h12345678_9ABCDEF0);

    // Sweep of every legal op
    for (int op = 0; op <= 11; op++) begin
      req0_valid = 1'b1; req0_op = 4'(op); req0_a = 32'hFFFFFFFF; req0_b = 32'hFFFFFFFF;
      run(20);
      chk_log("sweep", 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFF);
    end

    // Random traffic with hold-until-ready requesters and random backpressure
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid) begin
        req0_valid = ($urandom_range(0, 2) == 0);
        req0_op = 4'($urandom_range(0, 15)); req0_a = $urandom; req0_b = $urandom;
      end
      if (!req1_valid) begin
        req1_valid = ($urandom_range(0, 2) == 0);
        req1_op = 4'($urandom_range(0, 15)); req1_a = $urandom; req1_b = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    run(50);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
